// File: rtl/sensor_sample_logger_pkg.sv
// -----------------------------------------------------------------------------
// sensor_sample_logger_pkg
// Shared definitions for the light-sensor sample logger: default widths (the
// SPI master uses the same sample width), the FSM state encoding and a small
// edge-detect helper.
// -----------------------------------------------------------------------------
package sensor_sample_logger_pkg;

    localparam int SENSOR_DATA_W   = 8;
    localparam int SENSOR_ADDR_W   = 6;
    localparam int SENSOR_AVG_LOG2 = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_UPDATE  = 2'd2
    } state_t;

    // Rising edge of a level signal given its previous-cycle value.
    function automatic logic rise_edge(input logic level, input logic level_q);
        return level & ~level_q;
    endfunction

endpackage

// File: rtl/sensor_sample_logger_if.sv
// -----------------------------------------------------------------------------
// sensor_sample_logger_if
// Bus between the SPI master / display stage and the sample logger.
//   sample_rdy  master ready (level; rising edge marks a finished frame)
//   sample_in   master data (toMemory)
//   rd_en       random-access read request
//   rd_addr     absolute buffer address to read
//   rd_data     read data, one cycle after rd_en
// Modports: master drives frames and read requests, slave is the logger.
// -----------------------------------------------------------------------------
interface sensor_sample_logger_if
    import sensor_sample_logger_pkg::*;
#(
    parameter int DATA_W = SENSOR_DATA_W,
    parameter int ADDR_W = SENSOR_ADDR_W
);
    logic              sample_rdy;
    logic [DATA_W-1:0] sample_in;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output sample_rdy,
        output sample_in,
        output rd_en,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  sample_rdy,
        input  sample_in,
        input  rd_en,
        input  rd_addr,
        output rd_data
    );
endinterface

// File: rtl/sensor_sample_ram.sv
// -----------------------------------------------------------------------------
// sensor_sample_ram
// DEPTH x DATA_W sample buffer: one synchronous write port and two synchronous
// read ports (A: oldest-sample lookup, B: external read). Reads return the
// pre-write contents when they hit the address being written. The array itself
// is never cleared; only the read registers reset.
// Ports: clk, rstn (sync, active-low), we/waddr/wdata,
//        re_a/raddr_a/rdata_a, re_b/raddr_b/rdata_b.
// -----------------------------------------------------------------------------
module sensor_sample_ram
    import sensor_sample_logger_pkg::*;
#(
    parameter int DATA_W = SENSOR_DATA_W,
    parameter int ADDR_W = SENSOR_ADDR_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_a_r;
    logic [DATA_W-1:0] rdata_b_r;

    // Write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read registers; non-blocking update gives read-before-write ordering.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rdata_a_r <= {DATA_W{1'b0}};
            rdata_b_r <= {DATA_W{1'b0}};
        end else begin
            if (re_a) begin
                rdata_a_r <= mem_r[raddr_a];
            end
            if (re_b) begin
                rdata_b_r <= mem_r[raddr_b];
            end
        end
    end

    assign rdata_a = rdata_a_r;
    assign rdata_b = rdata_b_r;
endmodule

// File: rtl/sensor_sample_logger.sv
// -----------------------------------------------------------------------------
// sensor_sample_logger
// Captures one sample per rising edge of the SPI master's ready into a circular
// buffer, keeps a running window sum over the last 2**AVG_LOG2 samples and
// publishes the truncated average. Edges arriving while a frame is still being
// processed are dropped and flagged by a sticky overrun bit.
// Ports: clk, rstn (sync, active-low), bus (slave modport: sample_rdy,
//        sample_in, rd_en, rd_addr, rd_data), last_sample, wr_ptr, fill,
//        avg_out, avg_valid, overrun.
// -----------------------------------------------------------------------------
module sensor_sample_logger
    import sensor_sample_logger_pkg::*;
#(
    parameter int DATA_W   = SENSOR_DATA_W,
    parameter int ADDR_W   = SENSOR_ADDR_W,
    parameter int AVG_LOG2 = SENSOR_AVG_LOG2
) (
    input  logic                 clk,
    input  logic                 rstn,
    sensor_sample_logger_if.slave bus,
    output logic [DATA_W-1:0]    last_sample,
    output logic [ADDR_W-1:0]    wr_ptr,
    output logic [ADDR_W:0]      fill,
    output logic [DATA_W-1:0]    avg_out,
    output logic                 avg_valid,
    output logic                 overrun
);
    localparam int SUM_W  = DATA_W + AVG_LOG2;
    localparam int FILL_W = ADDR_W + 1;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int WIN    = 1 << AVG_LOG2;

    localparam logic [FILL_W-1:0] DEPTH_F = FILL_W'(DEPTH);
    localparam logic [FILL_W-1:0] WIN_F   = FILL_W'(WIN);
    // Truncates to zero when the window spans the whole buffer, which then
    // points the oldest-sample read at the slot about to be overwritten.
    localparam logic [ADDR_W-1:0] WIN_P   = ADDR_W'(WIN);
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [FILL_W-1:0] FILL_ONE = {{(FILL_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    state_t            state_nxt_s;
    logic              rdy_q_r;
    logic              frame_s;
    logic              capture_s;
    logic              update_s;
    logic [DATA_W-1:0] new_q_r;
    logic [DATA_W-1:0] old_q_s;
    logic [ADDR_W-1:0] old_addr_s;
    logic [SUM_W-1:0]  sum_r;
    logic [SUM_W-1:0]  sub_s;
    logic [SUM_W-1:0]  sum_nxt_s;
    logic [FILL_W-1:0] fill_r;
    logic [FILL_W-1:0] fill_nxt_s;
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [DATA_W-1:0] last_r;
    logic [DATA_W-1:0] avg_r;
    logic              avg_valid_r;
    logic              avg_pend_r;
    logic              overrun_r;
    logic [DATA_W-1:0] rd_data_s;

    // Frame detection, state decode and datapath next values.
    always_comb begin
        frame_s    = rise_edge(bus.sample_rdy, rdy_q_r);
        capture_s  = (state_r == ST_CAPTURE);
        update_s   = (state_r == ST_UPDATE);
        old_addr_s = wr_ptr_r - WIN_P;
        // The oldest sample only leaves the window once the window is full.
        if (fill_r >= WIN_F) begin
            sub_s = SUM_W'(old_q_s);
        end else begin
            sub_s = {SUM_W{1'b0}};
        end
        sum_nxt_s = sum_r + SUM_W'(new_q_r) - sub_s;
        if (fill_r == DEPTH_F) begin
            fill_nxt_s = fill_r;
        end else begin
            fill_nxt_s = fill_r + FILL_ONE;
        end
    end

    // FSM next-state: one IDLE -> CAPTURE -> UPDATE pass per accepted frame.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (frame_s) begin
                    state_nxt_s = ST_CAPTURE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CAPTURE: state_nxt_s = ST_UPDATE;
            ST_UPDATE:  state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Edge-detect history and sticky overrun; history resets high so a ready
    // already asserted when reset lifts is not taken as a new frame.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rdy_q_r   <= 1'b1;
            overrun_r <= 1'b0;
        end else begin
            rdy_q_r <= bus.sample_rdy;
            if (frame_s && (state_r != ST_IDLE)) begin
                overrun_r <= 1'b1;
            end
        end
    end

    // Sample capture (one cycle after the edge, once master data is stable)
    // and the UPDATE-cycle bookkeeping.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            new_q_r  <= {DATA_W{1'b0}};
            sum_r    <= {SUM_W{1'b0}};
            fill_r   <= {FILL_W{1'b0}};
            wr_ptr_r <= {ADDR_W{1'b0}};
            last_r   <= {DATA_W{1'b0}};
        end else begin
            if (capture_s) begin
                new_q_r <= bus.sample_in;
            end
            if (update_s) begin
                sum_r    <= sum_nxt_s;
                last_r   <= new_q_r;
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
                fill_r   <= fill_nxt_s;
            end
        end
    end

    // Average publication in the cycle after UPDATE, once the window is full.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            avg_pend_r  <= 1'b0;
            avg_r       <= {DATA_W{1'b0}};
            avg_valid_r <= 1'b0;
        end else begin
            avg_pend_r <= update_s;
            if (avg_pend_r && (fill_r >= WIN_F)) begin
                avg_r       <= sum_r[SUM_W-1:AVG_LOG2];
                avg_valid_r <= 1'b1;
            end else begin
                avg_valid_r <= 1'b0;
            end
        end
    end

    sensor_sample_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rstn    (rstn),
        .we      (capture_s),
        .waddr   (wr_ptr_r),
        .wdata   (bus.sample_in),
        .re_a    (capture_s),
        .raddr_a (old_addr_s),
        .rdata_a (old_q_s),
        .re_b    (bus.rd_en),
        .raddr_b (bus.rd_addr),
        .rdata_b (rd_data_s)
    );

    assign bus.rd_data = rd_data_s;
    assign last_sample = last_r;
    assign wr_ptr      = wr_ptr_r;
    assign fill        = fill_r;
    assign avg_out     = avg_r;
    assign avg_valid   = avg_valid_r;
    assign overrun     = overrun_r;
endmodule

// File: tb/tb_sensor_sample_logger.sv
// -----------------------------------------------------------------------------
// tb_sensor_sample_logger
// Randomised scoreboard bench for sensor_sample_logger. The driver issues
// frames and reads and pushes expected averages / read data into queues that a
// separate monitor pops whenever the DUT presents avg_valid or read data.
// The reference model keeps the stored history as a plain queue and an array.
// -----------------------------------------------------------------------------
module tb_sensor_sample_logger;
    import sensor_sample_logger_pkg::*;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 6;
    localparam int AVG_LOG2 = 3;
    localparam int DEPTH    = 64;
    localparam int WIN      = 8;

    logic              clk = 1'b0;
    logic              rstn;
    logic [DATA_W-1:0] last_sample;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   fill;
    logic [DATA_W-1:0] avg_out;
    logic              avg_valid;
    logic              overrun;

    sensor_sample_logger_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    sensor_sample_logger #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .AVG_LOG2 (AVG_LOG2)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .bus         (bus),
        .last_sample (last_sample),
        .wr_ptr      (wr_ptr),
        .fill        (fill),
        .avg_out     (avg_out),
        .avg_valid   (avg_valid),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0]  m_mem   [DEPTH];
    bit          m_known [DEPTH];
    int          m_wptr = 0;
    int          m_fill = 0;
    int unsigned m_last = 0;
    int unsigned m_hist [$];
    int unsigned avg_q  [$];
    int unsigned rd_q   [$];
    logic        rd_pending = 1'b0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_store(input logic [7:0] v);
        int unsigned s;
        m_mem[m_wptr]   = v;
        m_known[m_wptr] = 1'b1;
        m_wptr = (m_wptr + 1) % DEPTH;
        if (m_fill < DEPTH) m_fill++;
        m_last = v;
        m_hist.push_back(v);
        if (m_hist.size() > WIN) void'(m_hist.pop_front());
        if (m_fill >= WIN) begin
            s = 0;
            foreach (m_hist[i]) s += m_hist[i];
            avg_q.push_back(s / WIN);
        end
    endfunction

    function automatic void model_reset();
        m_wptr = 0;
        m_fill = 0;
        m_last = 0;
        m_hist.delete();
    endfunction

    // Monitor: note which cycles carried a read request.
    always @(posedge clk) rd_pending <= bus.rd_en;

    // Monitor: compare DUT outputs against the scoreboard queues.
    always @(negedge clk) begin
        if (rd_pending) begin
            if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
            else check("rd_data", bus.rd_data, rd_q.pop_front());
        end
        if (avg_valid) begin
            if (avg_q.size() == 0) check("avg_unexpected_pulse", 1, 0);
            else check("avg_out", avg_out, avg_q.pop_front());
        end
    end

    task automatic send_frame(input logic [7:0] v);
        @(negedge clk);
        bus.sample_rdy = 1'b1;
        bus.sample_in  = 8'($urandom);
        @(negedge clk);
        bus.sample_in  = v;
        model_store(v);
        @(negedge clk);
        @(negedge clk);
        bus.sample_rdy = 1'b0;
        repeat (2 + $urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic do_read(input int addr);
        if (m_known[addr]) begin
            @(negedge clk);
            bus.rd_en   = 1'b1;
            bus.rd_addr = 6'(addr);
            rd_q.push_back(m_mem[addr]);
            @(negedge clk);
            bus.rd_en = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_fill"}, fill, m_fill);
        check({tag, "_wr_ptr"}, wr_ptr, m_wptr);
        check({tag, "_last"}, last_sample, m_last);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] v;
        bus.sample_rdy = 1'b1;
        bus.sample_in  = 8'd0;
        bus.rd_en      = 1'b0;
        bus.rd_addr    = 6'd0;
        rstn           = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_last", last_sample, 0);
        check("rst_wr_ptr", wr_ptr, 0);
        check("rst_fill", fill, 0);
        check("rst_avg", avg_out, 0);
        check("rst_avg_valid", avg_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_rd_data", bus.rd_data, 0);

        // Ready held high through reset release: no capture.
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        check("hold_rdy_fill", fill, 0);
        check("hold_rdy_wr_ptr", wr_ptr, 0);
        bus.sample_rdy = 1'b0;
        repeat (2) @(negedge clk);

        // Frames 10..80: average appears only after the eighth.
        for (int i = 0; i < 8; i++) begin
            send_frame(8'((i + 1) * 10));
            if (i == 6) check("avg_before_full", avg_out, 0);
        end
        check("avg_first_window", avg_out, 45);
        check_state("t2");
        for (int a = 0; a < 8; a++) do_read(a);

        // Frame 90 slides the window.
        send_frame(8'd90);
        check("avg_slide", avg_out, 55);
        check("slide_wr_ptr", wr_ptr, 9);

        // 70 random frames from a clean reset: pointer wraps.
        do_reset();
        check_state("post_reset");
        for (int i = 0; i < 70; i++) send_frame(8'($urandom));
        check("wrap_wr_ptr", wr_ptr, 6);
        check("wrap_fill", fill, 64);
        check_state("t4");
        for (int a = 0; a < 6; a++) do_read(a);
        for (int i = 0; i < 10; i++) do_read(int'($urandom_range(0, DEPTH - 1)));

        // Read the slot being written in the CAPTURE cycle: old data returned.
        v = 8'($urandom);
        @(negedge clk);
        bus.sample_rdy = 1'b1;
        bus.sample_in  = 8'($urandom);
        @(negedge clk);
        bus.sample_in = v;
        bus.rd_en     = 1'b1;
        bus.rd_addr   = 6'(m_wptr);
        rd_q.push_back(m_mem[m_wptr]);
        model_store(v);
        @(negedge clk);
        bus.rd_en = 1'b0;
        @(negedge clk);
        bus.sample_rdy = 1'b0;
        repeat (3) @(negedge clk);
        check_state("rbw");

        // Second edge while busy: dropped, overrun sticks.
        check("overrun_clear", overrun, 0);
        v = 8'($urandom);
        @(negedge clk);
        bus.sample_rdy = 1'b1;
        bus.sample_in  = 8'($urandom);
        @(negedge clk);
        bus.sample_rdy = 1'b0;
        bus.sample_in  = v;
        model_store(v);
        @(negedge clk);
        bus.sample_rdy = 1'b1;
        bus.sample_in  = 8'($urandom);
        repeat (2) @(negedge clk);
        bus.sample_rdy = 1'b0;
        repeat (3) @(negedge clk);
        check("overrun_set", overrun, 1);
        check_state("overrun");
        for (int i = 0; i < 3; i++) send_frame(8'($urandom));
        check("overrun_sticky", overrun, 1);
        check_state("after_overrun");

        // Reset asserted in the UPDATE cycle: everything returns to zero.
        v = 8'($urandom);
        @(negedge clk);
        bus.sample_rdy = 1'b1;
        bus.sample_in  = 8'($urandom);
        @(negedge clk);
        bus.sample_in = v;
        m_mem[m_wptr]   = v;
        m_known[m_wptr] = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        model_reset();
        check("midrst_last", last_sample, 0);
        check("midrst_wr_ptr", wr_ptr, 0);
        check("midrst_fill", fill, 0);
        check("midrst_avg", avg_out, 0);
        check("midrst_avg_valid", avg_valid, 0);
        check("midrst_overrun", overrun, 0);
        check("midrst_rd_data", bus.rd_data, 0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_hold_fill", fill, 0);
        bus.sample_rdy = 1'b0;
        repeat (2) @(negedge clk);
        send_frame(8'($urandom));
        check_state("post_midrst");
        do_read(0);
        do_read(m_wptr);

        repeat (5) @(negedge clk);
        check("avg_queue_drained", avg_q.size(), 0);
        check("rd_queue_drained", rd_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
